lfsr_period_ctrl: RTL

Sequencing controller for the 8-bit LFSR datapath block. On a host start command it seeds the LFSR through its soft-reset port and steps it with a programmable-rate valid strobe. It counts steps until the LFSR output returns to the seed, then reports the measured period, or a timeout or zero-seed error. It sits between the host/config logic and the LFSR, and owns the LFSR's `i_valid`, `i_soft_reset` and `i_seed` inputs.

---
 rtl/lfsr_period_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/lfsr_period_ctrl.sv
// Sequencing controller for an external 8-bit LFSR: seeds it, steps it at a programmable
// rate and measures how many steps it takes to return to the seed.
module lfsr_period_ctrl #(
   parameter int          DW        = 8,
   parameter int          CW        = 16,
   parameter int unsigned MAX_STEPS = 2**CW - 1
) (
   input  logic          clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic [DW-1:0] i_seed,
   input  logic [3:0]    i_div,
   input  logic          i_abort,
   input  logic [DW-1:0] i_lfsr,
   output logic [DW-1:0] o_seed,
   output logic          o_soft_reset,
   output logic          o_valid,
   output logic          o_busy,
   output logic          o_done,
   output logic [CW-1:0] o_period,
   output logic          o_timeout,
   output logic          o_zero_err
);

   localparam logic [CW-1:0] MAX_C = CW'(MAX_STEPS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] seed_q, seed_d;
   logic [3:0]    div_q, div_d;
   logic [3:0]    dcnt_q, dcnt_d;
   logic [CW-1:0] steps_q, steps_d;
   logic          step_d_q, step_d_d;
   logic [CW-1:0] period_q, period_d;
   logic          timeout_q, timeout_d;
   logic          zero_err_q, zero_err_d;

   logic match;
   logic valid_c;

   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q    <= S_IDLE;
         seed_q     <= '0;
         div_q      <= '0;
         dcnt_q     <= '0;
         steps_q    <= '0;
         step_d_q   <= 1'b0;
         period_q   <= '0;
         timeout_q  <= 1'b0;
         zero_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         seed_q     <= seed_d;
         div_q      <= div_d;
         dcnt_q     <= dcnt_d;
         steps_q    <= steps_d;
         step_d_q   <= step_d_d;
         period_q   <= period_d;
         timeout_q  <= timeout_d;
         zero_err_q <= zero_err_d;
      end
   end

   // A match is only trusted one cycle after a step, once i_lfsr shows the stepped value.
   always_comb begin
      match   = (state_q == S_RUN) && step_d_q && (i_lfsr == seed_q);
      valid_c = (state_q == S_RUN) && (dcnt_q == div_q) && !match &&
                (steps_q != MAX_C) && !i_abort;
   end

   always_comb begin
      state_d    = state_q;
      seed_d     = seed_q;
      div_d      = div_q;
      dcnt_d     = dcnt_q;
      steps_d    = steps_q;
      step_d_d   = step_d_q;
      period_d   = period_q;
      timeout_d  = timeout_q;
      zero_err_d = zero_err_q;

      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               seed_d     = i_seed;
               div_d      = i_div;
               period_d   = '0;
               timeout_d  = 1'b0;
               zero_err_d = (i_seed == '0);
               state_d    = (i_seed == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            state_d = i_abort ? S_IDLE : S_SETTLE;
         end
         S_SETTLE: begin
            dcnt_d   = '0;
            steps_d  = '0;
            step_d_d = 1'b0;
            state_d  = i_abort ? S_IDLE : S_RUN;
         end
         S_RUN: begin
            step_d_d = valid_c;
            dcnt_d   = (dcnt_q == div_q) ? 4'd0 : dcnt_q + 4'd1;
            if (valid_c) begin
               steps_d = steps_q + CW'(1);
            end
            // Timeout waits for step_d to drop so the final step still gets its match check.
            if (i_abort) begin
               state_d = S_IDLE;
            end else if (match) begin
               period_d = steps_q;
               state_d  = S_DONE;
            end else if ((steps_q == MAX_C) && !step_d_q) begin
               period_d  = MAX_C;
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign o_seed       = seed_q;
   assign o_soft_reset = (state_q == S_LOAD);
   assign o_valid      = valid_c;
   assign o_busy       = (state_q != S_IDLE);
   assign o_done       = (state_q == S_DONE);
   assign o_period     = period_q;
   assign o_timeout    = timeout_q;
   assign o_zero_err   = zero_err_q;

endmodule
